// File: rtl/rpn_pkg.sv
// ============================================================================
// Module      : rpn_pkg
// Description : Shared types and constants for the RPN stack sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rpn_pkg;

   localparam int FLAGS_W = 4;

   // Encodings double as the status output code.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_EXEC = 2'd2
   } state_t;

   typedef logic [1:0] opcode_t;

   typedef enum logic [1:0] {
      UNDO_NONE = 2'd0,
      UNDO_PUSH = 2'd1,
      UNDO_OP   = 2'd2
   } undo_t;

endpackage

`default_nettype wire

// File: rtl/rpn_stack_mem.sv
// ============================================================================
// Module      : rpn_stack_mem
// Description : DEPTH x WIDTH operand array with entry counter, two write
//               ports and top / below-top read ports. No control decisions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rpn_stack_mem #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       i_wr0_en,
   input  logic [$clog2(DEPTH)-1:0]   i_wr0_idx,
   input  logic [WIDTH-1:0]           i_wr0_data,
   input  logic                       i_wr1_en,
   input  logic [$clog2(DEPTH)-1:0]   i_wr1_idx,
   input  logic [WIDTH-1:0]           i_wr1_data,
   input  logic                       i_inc,
   input  logic                       i_dec,
   output logic [WIDTH-1:0]           o_top,
   output logic [WIDTH-1:0]           o_below,
   output logic [$clog2(DEPTH+1)-1:0] o_depth
);

   localparam int AW = $clog2(DEPTH);
   localparam int DW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [DW-1:0]    r_depth;
   logic [AW-1:0]    w_idx_m1;
   logic [AW-1:0]    w_idx_m2;

   assign w_idx_m1 = AW'(r_depth - DW'(1));
   assign w_idx_m2 = AW'(r_depth - DW'(2));

   assign o_top   = (r_depth == '0)     ? '0 : r_mem[w_idx_m1];
   assign o_below = (r_depth < DW'(2))  ? '0 : r_mem[w_idx_m2];
   assign o_depth = r_depth;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_depth <= '0;
      end else begin
         if (i_wr0_en) begin
            r_mem[i_wr0_idx] <= i_wr0_data;
         end
         if (i_wr1_en) begin
            r_mem[i_wr1_idx] <= i_wr1_data;
         end
         if (i_inc) begin
            r_depth <= r_depth + DW'(1);
         end else if (i_dec) begin
            r_depth <= r_depth - DW'(1);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/rpn_stack_sequencer.sv
// ============================================================================
// Module      : rpn_stack_sequencer
// Description : Operand-stack controller sequencing the shared RPN ALU.
//               Optional macro RPN_UNDO_EN enables one-level undo.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rpn_stack_sequencer
   import rpn_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       op_req,
   input  logic [1:0]                 op_code,
   input  logic                       undo,
   input  logic [WIDTH-1:0]           data_in,
   output logic [WIDTH-1:0]           alu_a,
   output logic [WIDTH-1:0]           alu_b,
   output logic [1:0]                 alu_opcode,
   input  logic [WIDTH-1:0]           alu_result,
   input  logic [3:0]                 alu_flags,
   output logic [WIDTH-1:0]           to_display,
   output logic [3:0]                 flags,
   output logic [$clog2(DEPTH+1)-1:0] depth,
   output logic                       busy,
   output logic [2:0]                 status,
   output logic                       err_underflow,
   output logic                       err_overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int DW = $clog2(DEPTH+1);

   state_t               r_state;
   state_t               w_state_nxt;
   opcode_t              r_op;
   logic [WIDTH-1:0]     r_alu_a;
   logic [WIDTH-1:0]     r_alu_b;
   opcode_t              r_alu_op;
   logic [FLAGS_W-1:0]   r_flags;
   logic                 r_err_ovf;
   logic                 r_err_unf;

   logic                 w_wr0_en;
   logic [AW-1:0]        w_wr0_idx;
   logic [WIDTH-1:0]     w_wr0_data;
   logic                 w_wr1_en;
   logic [AW-1:0]        w_wr1_idx;
   logic [WIDTH-1:0]     w_wr1_data;
   logic                 w_inc;
   logic                 w_dec;
   logic                 w_err_ovf;
   logic                 w_err_unf;
   logic                 w_op_accept;
   logic [WIDTH-1:0]     w_top;
   logic [WIDTH-1:0]     w_below;
   logic [DW-1:0]        w_depth;
   logic [AW-1:0]        w_idx_d;
   logic [AW-1:0]        w_idx_m1;
   logic [AW-1:0]        w_idx_m2;

`ifdef RPN_UNDO_EN
   undo_t                r_undo;
   logic [FLAGS_W-1:0]   r_shadow_flags;
   logic                 w_push_accept;
   logic                 w_undo_accept;
   logic                 w_undo_op;
`endif

   rpn_stack_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk        (clk),
      .reset      (reset),
      .i_wr0_en   (w_wr0_en),
      .i_wr0_idx  (w_wr0_idx),
      .i_wr0_data (w_wr0_data),
      .i_wr1_en   (w_wr1_en),
      .i_wr1_idx  (w_wr1_idx),
      .i_wr1_data (w_wr1_data),
      .i_inc      (w_inc),
      .i_dec      (w_dec),
      .o_top      (w_top),
      .o_below    (w_below),
      .o_depth    (w_depth)
   );

   assign w_idx_d  = AW'(w_depth);
   assign w_idx_m1 = AW'(w_depth - DW'(1));
   assign w_idx_m2 = AW'(w_depth - DW'(2));

   always_comb begin
      w_state_nxt = r_state;
      w_wr0_en    = 1'b0;
      w_wr0_idx   = w_idx_d;
      w_wr0_data  = data_in;
      w_wr1_en    = 1'b0;
      w_wr1_idx   = w_idx_d;
      w_wr1_data  = r_alu_b;
      w_inc       = 1'b0;
      w_dec       = 1'b0;
      w_err_ovf   = 1'b0;
      w_err_unf   = 1'b0;
      w_op_accept = 1'b0;
`ifdef RPN_UNDO_EN
      w_push_accept = 1'b0;
      w_undo_accept = 1'b0;
      w_undo_op     = 1'b0;
`endif
      case (r_state)
         ST_IDLE: begin
            if (undo) begin
`ifdef RPN_UNDO_EN
               // Restoring an op re-creates both operands: A below, B on top.
               case (r_undo)
                  UNDO_PUSH: begin
                     w_dec         = 1'b1;
                     w_undo_accept = 1'b1;
                  end
                  UNDO_OP: begin
                     w_wr0_en      = 1'b1;
                     w_wr0_idx     = w_idx_m1;
                     w_wr0_data    = r_alu_a;
                     w_wr1_en      = 1'b1;
                     w_inc         = 1'b1;
                     w_undo_accept = 1'b1;
                     w_undo_op     = 1'b1;
                  end
                  default: w_err_unf = 1'b1;
               endcase
`else
               if (w_depth == '0) begin
                  w_err_unf = 1'b1;
               end else begin
                  w_dec = 1'b1;
               end
`endif
            end else if (op_req) begin
               if (w_depth >= DW'(2)) begin
                  w_op_accept = 1'b1;
                  w_state_nxt = ST_LOAD;
               end else begin
                  w_err_unf = 1'b1;
               end
            end else if (push) begin
               if (w_depth < DW'(DEPTH)) begin
                  w_wr0_en = 1'b1;
                  w_inc    = 1'b1;
`ifdef RPN_UNDO_EN
                  w_push_accept = 1'b1;
`endif
               end else begin
                  w_err_ovf = 1'b1;
               end
            end
         end
         ST_LOAD: w_state_nxt = ST_EXEC;
         ST_EXEC: begin
            w_state_nxt = ST_IDLE;
            w_wr0_en    = 1'b1;
            w_wr0_idx   = w_idx_m2;
            w_wr0_data  = alu_result;
            w_dec       = 1'b1;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_op      <= '0;
         r_alu_a   <= '0;
         r_alu_b   <= '0;
         r_alu_op  <= '0;
         r_flags   <= '0;
         r_err_ovf <= 1'b0;
         r_err_unf <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_err_ovf <= w_err_ovf;
         r_err_unf <= w_err_unf;
         if (w_op_accept) begin
            r_op <= op_code;
         end
         if (r_state == ST_LOAD) begin
            r_alu_a  <= w_below;
            r_alu_b  <= w_top;
            r_alu_op <= r_op;
         end
         if (r_state == ST_EXEC) begin
            r_flags <= alu_flags;
         end
`ifdef RPN_UNDO_EN
         else if (w_undo_op) begin
            r_flags <= r_shadow_flags;
         end
`endif
      end
   end

`ifdef RPN_UNDO_EN
   // The ALU operand registers stay untouched until the next op, so they
   // double as the operand shadow for undo.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_undo         <= UNDO_NONE;
         r_shadow_flags <= '0;
      end else if (r_state == ST_EXEC) begin
         r_undo         <= UNDO_OP;
         r_shadow_flags <= r_flags;
      end else if (w_push_accept) begin
         r_undo <= UNDO_PUSH;
      end else if (w_undo_accept || w_err_ovf || w_err_unf) begin
         r_undo <= UNDO_NONE;
      end
   end
`endif

   assign alu_a         = r_alu_a;
   assign alu_b         = r_alu_b;
   assign alu_opcode    = r_alu_op;
   assign to_display    = w_top;
   assign flags         = r_flags;
   assign depth         = w_depth;
   assign busy          = (r_state != ST_IDLE);
   assign status        = {1'b0, r_state};
   assign err_underflow = r_err_unf;
   assign err_overflow  = r_err_ovf;

endmodule

`default_nettype wire

// File: tb/tb_rpn_stack_sequencer.sv
// ============================================================================
// Module      : tb_rpn_stack_sequencer
// Description : Self-checking bench for rpn_stack_sequencer (queue model).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rpn_stack_sequencer;

   localparam int WIDTH = 16;
   localparam int DEPTH = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              push = 1'b0;
   logic              op_req = 1'b0;
   logic [1:0]        op_code = 2'b00;
   logic              undo = 1'b0;
   logic [WIDTH-1:0]  data_in = '0;
   logic [WIDTH-1:0]  alu_a, alu_b, alu_result, to_display;
   logic [1:0]        alu_opcode;
   logic [3:0]        alu_flags, flags;
   logic [2:0]        depth;
   logic              busy, err_underflow, err_overflow;
   logic [2:0]        status;

   int errors = 0;
   int checks = 0;

   logic [WIDTH-1:0]  stk[$];
   logic [3:0]        m_flags = '0;
   logic [3:0]        s_flags = '0;
   logic [WIDTH-1:0]  s_a = '0, s_b = '0;
   int                m_undo = 0;

   rpn_stack_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .push(push), .op_req(op_req), .op_code(op_code),
      .undo(undo), .data_in(data_in), .alu_a(alu_a), .alu_b(alu_b),
      .alu_opcode(alu_opcode), .alu_result(alu_result), .alu_flags(alu_flags),
      .to_display(to_display), .flags(flags), .depth(depth), .busy(busy),
      .status(status), .err_underflow(err_underflow), .err_overflow(err_overflow)
   );

   always #5 clk = ~clk;

   function automatic logic [WIDTH-1:0] alu_r(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, logic [1:0] op);
      case (op)
         2'b00:   return a + b;
         2'b01:   return a - b;
         2'b10:   return a & b;
         default: return a ^ b;
      endcase
   endfunction

   function automatic logic [3:0] alu_f(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, logic [1:0] op);
      logic [WIDTH:0]   c;
      logic [WIDTH-1:0] r;
      r = alu_r(a, b, op);
      c = (op == 2'b00) ? ({1'b0, a} + {1'b0, b}) : ({1'b0, a} - {1'b0, b});
      return {r[WIDTH-1], (r == '0), c[WIDTH], 1'b0};
   endfunction

   always_comb begin
      alu_result = alu_r(alu_a, alu_b, alu_opcode);
      alu_flags  = alu_f(alu_a, alu_b, alu_opcode);
   end

   function automatic logic [WIDTH-1:0] m_top();
      return (stk.size() == 0) ? '0 : stk[stk.size()-1];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_state(input string tag);
      chk({tag, ".depth"},   32'(depth),      32'(stk.size()));
      chk({tag, ".display"}, 32'(to_display), 32'(m_top()));
      chk({tag, ".flags"},   32'(flags),      32'(m_flags));
      chk({tag, ".busy"},    32'(busy),       32'd0);
      chk({tag, ".status"},  32'(status),     32'd0);
   endtask

   task automatic junk();
      logic [31:0] r;
      r = $urandom;
      push = r[0]; op_req = r[1]; undo = r[2]; op_code = r[4:3]; data_in = r[31:16];
   endtask

   task automatic idle_inputs();
      push = 1'b0; op_req = 1'b0; undo = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle_inputs();
      reset = 1'b1;
      @(posedge clk); #1;
      stk.delete(); m_flags = '0; m_undo = 0;
      chk("rst.alu_a", 32'(alu_a), 32'd0);
      chk("rst.alu_b", 32'(alu_b), 32'd0);
      chk("rst.err", {30'd0, err_underflow, err_overflow}, 32'd0);
      chk_state("rst");
      @(negedge clk);
      reset = 1'b0;
   endtask

   // One stimulus cycle, then the whole model-predicted response.
   task automatic act(input string tag, input logic p, input logic o, input logic u,
                      input logic [WIDTH-1:0] d, input logic [1:0] oc);
      logic             e_ovf, e_unf, go;
      logic [WIDTH-1:0] a, b;
      e_ovf = 1'b0; e_unf = 1'b0; go = 1'b0; a = '0; b = '0;
      @(negedge clk);
      push = p; op_req = o; undo = u; data_in = d; op_code = oc;
      if (u) begin
`ifdef RPN_UNDO_EN
         if (m_undo == 1) void'(stk.pop_back());
         else if (m_undo == 2) begin
            void'(stk.pop_back());
            stk.push_back(s_a); stk.push_back(s_b);
            m_flags = s_flags;
         end else e_unf = 1'b1;
         m_undo = 0;
`else
         if (stk.size() == 0) e_unf = 1'b1;
         else void'(stk.pop_back());
`endif
      end else if (o) begin
         if (stk.size() >= 2) begin
            go = 1'b1; a = stk[stk.size()-2]; b = stk[stk.size()-1];
         end else begin
            e_unf = 1'b1; m_undo = 0;
         end
      end else if (p) begin
         if (stk.size() < DEPTH) begin
            stk.push_back(d); m_undo = 1;
         end else begin
            e_ovf = 1'b1; m_undo = 0;
         end
      end
      @(posedge clk); #1;
      idle_inputs();
      chk({tag, ".ovf"}, 32'(err_overflow), 32'(e_ovf));
      chk({tag, ".unf"}, 32'(err_underflow), 32'(e_unf));
      if (go) begin
         chk({tag, ".busy1"}, {29'd0, busy, status[1:0]}, 32'b101);
         junk();
         @(posedge clk); #1;
         chk({tag, ".busy2"}, {29'd0, busy, status[1:0]}, 32'b110);
         chk({tag, ".alu_a"}, 32'(alu_a), 32'(a));
         chk({tag, ".alu_b"}, 32'(alu_b), 32'(b));
         chk({tag, ".alu_op"}, 32'(alu_opcode), 32'(oc));
         junk();
         @(posedge clk); #1;
         idle_inputs();
         void'(stk.pop_back()); void'(stk.pop_back());
         stk.push_back(alu_r(a, b, oc));
         s_a = a; s_b = b; s_flags = m_flags;
         m_flags = alu_f(a, b, oc);
         m_undo = 2;
         chk({tag, ".nopulse"}, {30'd0, err_underflow, err_overflow}, 32'd0);
      end
      chk_state(tag);
   endtask

   initial begin
      logic [31:0] r;
      logic        p, o, u;
      do_reset();

      act("p5", 1, 0, 0, 16'd5, 2'b00);
      act("p3", 1, 0, 0, 16'd3, 2'b00);
      act("sub", 0, 1, 0, 16'd0, 2'b01);
      chk("sub.const", {29'd0, depth}, 32'd1);
      chk("sub.val", 32'(to_display), 32'd2);

      do_reset();
      act("p7", 1, 0, 0, 16'd7, 2'b00);
      act("unf", 0, 1, 0, 16'd0, 2'b00);
      chk("unf.val", 32'(to_display), 32'd7);

      do_reset();
      for (int i = 1; i <= 4; i++) act("fill", 1, 0, 0, 16'(i), 2'b00);
      act("ovf", 1, 0, 0, 16'd9, 2'b00);
      chk("ovf.val", {13'd0, depth, to_display}, {13'd0, 3'd4, 16'd4});

      do_reset();
      act("p10", 1, 0, 0, 16'd10, 2'b00);
      act("p20", 1, 0, 0, 16'd20, 2'b00);
      act("add", 0, 1, 0, 16'd0, 2'b00);
      chk("add.val", 32'(to_display), 32'd30);

      // Reset landing in EXEC discards the operation entirely.
      do_reset();
      act("p4", 1, 0, 0, 16'd4, 2'b00);
      act("p6", 1, 0, 0, 16'd6, 2'b00);
      @(negedge clk); op_req = 1'b1; op_code = 2'b00;
      @(negedge clk); op_req = 1'b0;
      chk("abort.in_load", 32'(status), 32'd1);
      @(negedge clk);
      chk("abort.in_exec", 32'(status), 32'd2);
      reset = 1'b1;
      @(posedge clk); #1;
      stk.delete(); m_flags = '0; m_undo = 0;
      chk_state("abort");
      @(negedge clk); reset = 1'b0;

      do_reset();
      act("p8", 1, 0, 0, 16'd8, 2'b00);
      act("p2", 1, 0, 0, 16'd2, 2'b00);
      act("u.sub", 0, 1, 0, 16'd0, 2'b01);
      chk("u.val", 32'(to_display), 32'd6);
      act("undo", 0, 0, 1, 16'd0, 2'b00);
`ifdef RPN_UNDO_EN
      chk("undo.en", {13'd0, depth, to_display}, {13'd0, 3'd2, 16'd2});
`else
      chk("undo.dis", {13'd0, depth, to_display}, 32'd0);
`endif
      act("undo2", 0, 0, 1, 16'd0, 2'b00);
      act("u.op2", 0, 1, 0, 16'd0, 2'b01);

      do_reset();
      for (int i = 0; i < 300; i++) begin
         r = $urandom;
         p = (r[6:0] < 7'd60);
         o = (r[6:0] >= 7'd60) && (r[6:0] < 7'd100);
         u = (r[6:0] >= 7'd100) && (r[6:0] < 7'd120);
         if (r[10:8] == 3'd0) begin
            p = p | r[11]; o = o | r[12]; u = u | r[13];
         end
         act("rnd", p, o, u, (r[14] ? r[31:16] : {12'd0, r[19:16]}), r[21:20]);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
